line_fetch: RTL and testbench
=============================

# line_fetch

Upstream feeder for the composite synthesizer's 320×8 line buffer. On a per-line request from the video timing logic, it reads one line of colour numbers from the synchronous frame memory and streams them, one per clock, into the line buffer's `write`/`data_i` port. It runs only when the buffer reports `ready`. Out-of-range lines are filled with a blank colour, and the frame memory is not touched for them.

## Interface

Parameters:
- `H_PIXELS`, 320: pixels per line (must equal line buffer depth).
- `V_LINES`, 240: visible lines held in frame memory.
- `ADDR_W`, 17: frame memory address width (≥ ceil(log2(H_PIXELS·V_LINES))).
- `DATA_W`, 8: colour number width.
- `BLANK_COLOUR`, 8'h00: fill value for lines ≥ `V_LINES`.

Ports. Clocking: one clock; reset is asynchronous and active-high.
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high.
- `line_req`, in, 1: single-cycle request to load a line.
- `line_num`, in, 8: line index, sampled with `line_req`.
- `ready`, in, 1: line buffer can accept a full line.
- `mem_rd`, out, 1: frame memory read strobe.
- `mem_addr`, out, `ADDR_W`: frame memory address.
- `mem_data`, in, `DATA_W`: read data, valid one cycle after `mem_rd`.
- `write`, out, 1: line buffer write strobe.
- `data_o`, out, `DATA_W`: colour number to line buffer `data_i`.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse after the last write of a line.
- `overrun`, out, 1: sticky flag, set when a request is dropped.
- `overrun_clr`, in, 1: synchronous clear of `overrun`.

## Operation

States: IDLE, WAIT_READY, FETCH, DRAIN.

- **IDLE.**
  - On `line_req`: latch `line_num`.
  - Compute `base = line_num·H_PIXELS`. The default uses shift-add, (n<<8)+(n<<6), truncated to `ADDR_W`.
  - Set `blank_line = (line_num >= V_LINES)`, then go to WAIT_READY.
- **WAIT_READY.** Hold until `ready` is sampled high, then go to FETCH with column counter `col` = 0.
- **FETCH.** Runs exactly `H_PIXELS` cycles.
  - Each cycle: `mem_addr = base + col` and `col++`.
  - `mem_rd = !blank_line`.
  - After `col == H_PIXELS-1`, go to DRAIN.
- **DRAIN.** Lasts 2 cycles, to empty the read pipeline, then return to IDLE.
- **Read pipeline.** Two registered stages: `v1 <= in_fetch`, `write <= v1`.
  - `data_o <= blank_line ? BLANK_COLOUR : mem_data`, captured when `v1`.
  - `write` is high for exactly `H_PIXELS` cycles per line and is contiguous.
- **`ready` after start.** Not re-checked once FETCH has begun. A `ready` drop mid-line is ignored, because the buffer accepts a whole line once it has asserted `ready`.
- **Request while busy.** A `line_req` in any state other than IDLE (including the cycle `done` is high) is dropped and sets `overrun`.
  - `overrun_clr` clears `overrun`.
  - If set and clear occur in the same cycle, set wins.
- **Addressing.** `col` is `ceil(log2(H_PIXELS))` bits wide and never wraps inside a line. The `mem_addr` sum is truncated to `ADDR_W`.

## Timing

- **Reset values:** `mem_rd`, `mem_addr`, `write`, `data_o`, `busy`, `done`, `overrun` all 0; state IDLE; `col` 0.
- **Reset mid-line:** all of the above return to their reset values immediately. The partial line is abandoned, and the line buffer shares the same reset.
- **Cycle-level sequence**, with `line_req` at cycle 0 and `ready` already high:
  - Cycle 1: WAIT_READY.
  - Cycles 2 to 321: FETCH, `mem_rd` high.
  - Cycles 4 to 323: `write` high.
  - Cycle 324: `done` pulse, `busy` low, state IDLE; a new `line_req` is accepted this cycle.
- **`busy`:** rises in cycle 1.
- **Throughput:** worst case `H_PIXELS`+4 cycles per line plus the time spent waiting for `ready`.
- **`mem_addr` hold:** holds its last value outside FETCH.

## Structure

- Shared include `video_defs.vh` holds:
  - state encodings: IDLE=0, WAIT_READY=1, FETCH=2, DRAIN=3;
  - `H_PIXELS` and `V_LINES` defaults;
  - `BLANK_COLOUR`.
- One natural sub-module, `line_addr_gen`, contains the base multiply (shift-add), the column counter and the `last_col` flag.
- The FSM and the read pipeline stay in `line_fetch`.

## Test plan

- **Nominal line.** `line_num`=3, `ready`=1; memory returns `addr[7:0]`.
  - Exactly 320 `write` pulses on cycles 4 to 323.
  - `data_o` sequence covers addresses 960 to 1279.
  - `done` at cycle 324.
- **Ready stall.** `ready`=0 for 50 cycles after `line_req`.
  - `mem_rd` stays low until the cycle after `ready` rises.
  - Then 320 contiguous writes; no read occurs while stalled.
- **Blank line.** `line_num`=240.
  - `mem_rd` never asserts.
  - 320 writes of 8'h00.
  - `done` follows with normal timing.
- **Overrun.** Second `line_req` during FETCH.
  - `overrun`=1 from the next cycle; the current line completes unaffected.
  - `overrun_clr` returns it to 0.
  - `line_req` in the `done` cycle is accepted.
- **Reset mid-FETCH.** Assert `reset` at `col`=100.
  - All outputs are 0 within the same cycle.
  - After release, a fresh request to line 239 reads from `base`=76480.
- **Back-to-back.** Lines 0, 1, 2 are requested on their `done` cycles.
  - 960 total writes; addresses 0 to 959 with no gap or duplicate.

Source files
------------

// File: rtl/line_fetch_pkg.sv
// Shared constants for the line fetcher: parameter defaults and FSM state encodings.
package line_fetch_pkg;

   localparam int unsigned H_PIXELS_DEF = 320;
   localparam int unsigned V_LINES_DEF  = 240;
   localparam int unsigned ADDR_W_DEF   = 17;
   localparam int unsigned DATA_W_DEF   = 8;

   localparam logic [7:0] BLANK_COLOUR_DEF = 8'h00;

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_WAIT_READY = 2'd1;
   localparam logic [1:0] ST_FETCH      = 2'd2;
   localparam logic [1:0] ST_DRAIN      = 2'd3;

endpackage

// File: rtl/line_addr_gen.sv
// Line base address, column counter and frame memory address register.
module line_addr_gen #(
   parameter int unsigned H_PIXELS = 320,
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned COL_W    = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [7:0]        line_num_i,
   input  logic              start_i,
   input  logic              step_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_col_c
);

   logic [ADDR_W-1:0] base_c;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [COL_W-1:0]  col_q, col_d;

   // 320 = 256 + 64, so the default width avoids a multiplier
   if (H_PIXELS == 32'd320) begin : g_shift_add
      assign base_c = (ADDR_W'(line_num_i) << 8) + (ADDR_W'(line_num_i) << 6);
   end else begin : g_mul
      assign base_c = ADDR_W'(32'(line_num_i) * H_PIXELS);
   end

   always_comb begin
      base_d = base_q;
      col_d  = col_q;
      addr_d = addr_q;
      if (load_i) begin
         base_d = base_c;
      end
      if (start_i) begin
         col_d  = '0;
         addr_d = base_q;
      end else if (step_i) begin
         col_d  = col_q + COL_W'(1);
         addr_d = base_q + ADDR_W'(col_d);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q <= '0;
         col_q  <= '0;
         addr_q <= '0;
      end else begin
         base_q <= base_d;
         col_q  <= col_d;
         addr_q <= addr_d;
      end
   end

   assign last_col_c = (col_q == COL_W'(H_PIXELS - 1));
   assign addr_o     = addr_q;

endmodule

// File: rtl/line_fetch.sv
// Streams one line of colour numbers from frame memory into the line buffer
// through a two-stage read pipeline, filling out-of-range lines with a blank colour.
module line_fetch
   import line_fetch_pkg::*;
#(
   parameter int unsigned H_PIXELS = H_PIXELS_DEF,
   parameter int unsigned V_LINES  = V_LINES_DEF,
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter logic [DATA_W-1:0] BLANK_COLOUR = DATA_W'(BLANK_COLOUR_DEF)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              line_req,
   input  logic [7:0]        line_num,
   input  logic              ready,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              write,
   output logic [DATA_W-1:0] data_o,
   output logic              busy,
   output logic              done,
   output logic              overrun,
   input  logic              overrun_clr
);

   localparam int unsigned COL_W = $clog2(H_PIXELS);

   logic [1:0]        state_q, state_d;
   logic              drain_q, drain_d;
   logic              blank_q, blank_d;
   logic              v1_q, v1_d;
   logic              write_q, write_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              mem_rd_q, mem_rd_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              overrun_q, overrun_d;
   logic              load_c, start_c, step_c, last_col_c;

   line_addr_gen #(
      .H_PIXELS (H_PIXELS),
      .ADDR_W   (ADDR_W),
      .COL_W    (COL_W)
   ) u_addr_gen (
      .clk        (clk),
      .reset      (reset),
      .load_i     (load_c),
      .line_num_i (line_num),
      .start_i    (start_c),
      .step_i     (step_c),
      .addr_o     (mem_addr),
      .last_col_c (last_col_c)
   );

   // Next-state, strobes and registered-output next values
   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      blank_d   = blank_q;
      load_c    = 1'b0;
      start_c   = 1'b0;
      step_c    = 1'b0;
      done_d    = 1'b0;
      overrun_d = overrun_q;

      if (overrun_clr) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (line_req) begin
               load_c  = 1'b1;
               blank_d = (32'(line_num) >= V_LINES);
               state_d = ST_WAIT_READY;
            end
         end
         ST_WAIT_READY: begin
            if (ready) begin
               start_c = 1'b1;
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (last_col_c) begin
               drain_d = 1'b0;
               state_d = ST_DRAIN;
            end else begin
               step_c = 1'b1;
            end
         end
         ST_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) begin
               drain_d = 1'b0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A dropped request outranks a clear in the same cycle
      if (line_req && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end

      mem_rd_d = (state_d == ST_FETCH) && !blank_d;
      busy_d   = (state_d != ST_IDLE);
      v1_d     = (state_q == ST_FETCH);
      write_d  = v1_q;
      data_d   = data_q;
      if (v1_q) begin
         data_d = blank_q ? BLANK_COLOUR : mem_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         drain_q   <= 1'b0;
         blank_q   <= 1'b0;
         v1_q      <= 1'b0;
         write_q   <= 1'b0;
         data_q    <= '0;
         mem_rd_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         drain_q   <= drain_d;
         blank_q   <= blank_d;
         v1_q      <= v1_d;
         write_q   <= write_d;
         data_q    <= data_d;
         mem_rd_q  <= mem_rd_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
      end
   end

   assign mem_rd  = mem_rd_q;
   assign write   = write_q;
   assign data_o  = data_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_line_fetch.sv
// Self-checking bench for line_fetch: vector table, hand sequences and random lines
// compared against a per-line timing/data model built from pixel arithmetic.
module tb_line_fetch;

   localparam int H  = 320;
   localparam int VL = 240;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        line_req = 1'b0;
   logic [7:0]  line_num = 8'd0;
   logic        ready = 1'b0;
   logic        overrun_clr = 1'b0;
   logic        mem_rd, write, busy, done, overrun;
   logic [16:0] mem_addr;
   logic [7:0]  mem_data;
   logic [7:0]  data_o;

   int checks = 0;
   int failures = 0;
   int rd_log[$];
   bit log_en = 1'b0;

   typedef struct {
      int line;
      int stall;
      int base;
      bit blank;
      bit jitter;
   } vec_t;

   vec_t tbl[6];

   always #5 clk = ~clk;

   line_fetch #(
      .H_PIXELS (320),
      .V_LINES  (240),
      .ADDR_W   (17),
      .DATA_W   (8),
      .BLANK_COLOUR (8'h00)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .line_req    (line_req),
      .line_num    (line_num),
      .ready       (ready),
      .mem_rd      (mem_rd),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .write       (write),
      .data_o      (data_o),
      .busy        (busy),
      .done        (done),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   // Frame memory contents: an address hash so misordered reads show up in the data
   function automatic logic [7:0] memf(input int a);
      int m;
      m = a & 32'h1ffff;
      return 8'((m ^ (m >> 8)) ^ 32'h5a);
   endfunction

   always @(posedge clk) begin
      if (mem_rd) mem_data <= memf(int'(mem_addr));
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full line starting in the current cycle (cycle 0); returns in the done cycle.
   task automatic run_line(input string tag, input int n, input int stall, input int exp_base,
                           input bit exp_blank, input bit jitter, input bit ovr);
      int f, rd_cnt, wr_cnt, rd_bad, wr_bad, busy_bad, done_cnt, done_at;
      f = (stall + 1 > 2) ? stall + 1 : 2;
      rd_cnt = 0; wr_cnt = 0; rd_bad = 0; wr_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
      line_num = 8'(n);
      line_req = 1'b1;
      ready    = (stall == 0);
      for (int k = 1; k <= f + 322; k++) begin
         tick();
         if (mem_rd) begin
            rd_cnt++;
            if (k < f || k > f + 319) rd_bad++;
            else if (int'(mem_addr) != ((exp_base + k - f) & 32'h1ffff)) rd_bad++;
            if (log_en) rd_log.push_back(int'(mem_addr));
         end
         if (write) begin
            wr_cnt++;
            if (k < f + 2 || k > f + 321) wr_bad++;
            else if (data_o != (exp_blank ? 8'h00 : memf(exp_base + k - f - 2))) wr_bad++;
         end
         if (busy != (k <= f + 321)) busy_bad++;
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = k;
         end
         if (ovr) begin
            if (k == f + 10) check({tag, "_ovr_pre"}, 64'(overrun), 64'd0);
            if (k == f + 11) check({tag, "_ovr_set"}, 64'(overrun), 64'd1);
            if (k == f + 21) check({tag, "_ovr_setwins"}, 64'(overrun), 64'd1);
            if (k == f + 31) check({tag, "_ovr_clr"}, 64'(overrun), 64'd0);
         end
         line_req    = 1'b0;
         overrun_clr = 1'b0;
         if (k == stall) ready = 1'b1;
         if (jitter && k >= f) ready = 1'($urandom);
         if (ovr && (k == f + 10 || k == f + 20)) begin
            line_req = 1'b1;
            line_num = 8'(n ^ 8'h81);
         end
         if (ovr && (k == f + 20 || k == f + 30)) overrun_clr = 1'b1;
      end
      check({tag, "_rd_count"}, 64'(rd_cnt), exp_blank ? 64'd0 : 64'(H));
      check({tag, "_rd_window_addr"}, 64'(rd_bad), 64'd0);
      check({tag, "_wr_count"}, 64'(wr_cnt), 64'(H));
      check({tag, "_wr_window_data"}, 64'(wr_bad), 64'd0);
      check({tag, "_busy"}, 64'(busy_bad), 64'd0);
      check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
      check({tag, "_done_cycle"}, 64'(done_at), 64'(f + 322));
      line_req    = 1'b0;
      overrun_clr = 1'b0;
   endtask

   function automatic logic [63:0] outs_now();
      return 64'({mem_rd, mem_addr, write, data_o, busy, done, overrun});
   endfunction

   initial begin
      int n, st, bad;
      tbl[0] = '{line: 3,   stall: 0,  base: 960,   blank: 1'b0, jitter: 1'b0};
      tbl[1] = '{line: 240, stall: 0,  base: 76800, blank: 1'b1, jitter: 1'b0};
      tbl[2] = '{line: 7,   stall: 50, base: 2240,  blank: 1'b0, jitter: 1'b0};
      tbl[3] = '{line: 255, stall: 3,  base: 81600, blank: 1'b1, jitter: 1'b1};
      tbl[4] = '{line: 100, stall: 1,  base: 32000, blank: 1'b0, jitter: 1'b1};
      tbl[5] = '{line: 12,  stall: 4,  base: 3840,  blank: 1'b0, jitter: 1'b0};

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", outs_now(), 64'd0);
      reset = 1'b0;
      tick();
      check("idle_outputs", outs_now(), 64'd0);

      for (int i = 0; i < 6; i++) begin
         run_line($sformatf("vec%0d", i), tbl[i].line, tbl[i].stall, tbl[i].base,
                  tbl[i].blank, tbl[i].jitter, 1'b0);
         tick(); tick();
      end

      // Overrun during FETCH; the line itself must complete untouched
      run_line("overrun", 9, 0, 2880, 1'b0, 1'b0, 1'b1);
      tick(); tick();

      // Reset at col 100 of line 5, then line 239
      line_num = 8'd5;
      line_req = 1'b1;
      ready    = 1'b1;
      for (int k = 1; k <= 102; k++) begin
         tick();
         line_req = 1'b0;
      end
      check("pre_reset_write", 64'(write), 64'd1);
      check("pre_reset_addr", 64'(mem_addr), 64'(1600 + 100));
      reset = 1'b1;
      #1;
      check("midline_reset_outputs", outs_now(), 64'd0);
      tick(); tick();
      reset = 1'b0;
      tick();
      check("post_reset_idle", outs_now(), 64'd0);
      run_line("line239", 239, 0, 76480, 1'b0, 1'b0, 1'b0);
      tick(); tick();

      // Back-to-back: each request issued in the previous line's done cycle
      rd_log.delete();
      log_en = 1'b1;
      run_line("b2b0", 0, 0, 0, 1'b0, 1'b0, 1'b0);
      run_line("b2b1", 1, 0, 320, 1'b0, 1'b0, 1'b0);
      run_line("b2b2", 2, 0, 640, 1'b0, 1'b0, 1'b0);
      log_en = 1'b0;
      check("b2b_total_reads", 64'(rd_log.size()), 64'd960);
      bad = 0;
      foreach (rd_log[i]) if (rd_log[i] != i) bad++;
      check("b2b_addr_sequence", 64'(bad), 64'd0);
      tick(); tick();

      // Random lines, stalls and mid-line ready jitter
      for (int r = 0; r < 8; r++) begin
         n  = int'($urandom_range(0, 255));
         st = int'($urandom_range(0, 8));
         run_line($sformatf("rnd%0d_l%0d", r, n), n, st, (n * H) & 32'h1ffff,
                  n >= VL, 1'b1, 1'b0);
         repeat ($urandom_range(0, 3)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
